// File: rtl/mem_port_pkg.sv
// Shared types and constants for the unified instruction/data memory port.
package mem_port_pkg;

    // Port controller state: wait for a request, run the handshake, release the CPU for one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Cycles mem_req may stay unacknowledged before the access is aborted (fits the 8-bit counter).
    localparam int TIMEOUT_DEFAULT = 255;

    // Byte-offset bits that must be zero for a word access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // True when the low address bits do not select a word boundary.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Watchdog for an outstanding memory request: counts unacknowledged cycles and
// flags the cycle whose increment would reach LIMIT.
module mem_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear wins over enable, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The current unacknowledged cycle is the LIMIT-th one.
    assign expired = enable && (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/mem_port_ctrl.sv
// Unified instruction/data memory port for the multicycle core: latches the
// access, runs a req/ack handshake with variable-latency memory, captures read
// data into IR or MDR, and stalls the control FSM until the access completes.
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic          i_or_d,
    input  logic          ir_write,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] alu_out,
    input  logic [DW-1:0] wdata,
    output logic          cpu_stall,
    output logic [DW-1:0] instr,
    output logic [DW-1:0] mdr,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          fetch_q, fetch_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [DW-1:0] mdr_q, mdr_d;
    logic          err_q, err_d;

    logic          cnt_clear;
    logic          cnt_en;
    logic          cnt_expired;
    logic [AW-1:0] req_addr;

    assign req_addr = i_or_d ? alu_out : pc;

    mem_timeout_cnt #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .expired(cnt_expired)
    );

    // Next-state, access latching, read-data capture and sticky error logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        fetch_d   = fetch_q;
        instr_d   = instr_q;
        mdr_d     = mdr_q;
        err_d     = err_q;
        cnt_clear = 1'b1;
        cnt_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    addr_d  = req_addr;
                    we_d    = cpu_we;
                    wdata_d = wdata;
                    fetch_d = ir_write;
                    // A misaligned access never reaches memory; release the CPU with err set.
                    if (is_misaligned(req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_clear = 1'b0;
                cnt_en    = !mem_ack;
                if (mem_ack) begin
                    if (!we_q) begin
                        if (fetch_q) begin
                            instr_d = mem_rdata;
                        end else begin
                            mdr_d = mem_rdata;
                        end
                    end
                    state_d = DONE;
                end else if (cnt_expired) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // cpu_req here belongs to the access just completed.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // An acknowledge with nothing outstanding indicates a broken memory model.
        if (mem_ack && (state_q != BUSY)) begin
            err_d = 1'b1;
        end
    end

    // State and capture registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            fetch_q <= 1'b0;
            instr_q <= '0;
            mdr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            fetch_q <= fetch_d;
            instr_q <= instr_d;
            mdr_q   <= mdr_d;
            err_q   <= err_d;
        end
    end

    // The request cycle stalls only if a request is present; reset forces the stall low at once.
    assign cpu_stall = !reset && ((state_q == BUSY) || ((state_q == IDLE) && cpu_req));
    assign mem_req   = (state_q == BUSY);
    assign mem_we    = (state_q == BUSY) && we_q;
    assign mem_addr  = addr_q & ~AW'(ALIGN_MASK);
    assign mem_wdata = wdata_q;
    assign instr     = instr_q;
    assign mdr       = mdr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: directed scenarios plus randomized
// accesses checked against a per-access reference model.
module tb_mem_port_ctrl;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, i_or_d, ir_write;
    logic [31:0] pc, alu_out, wdata;
    logic        cpu_stall;
    logic [31:0] instr, mdr;
    logic        err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    // Reference model of the architecturally visible registers.
    logic [31:0] exp_instr = '0;
    logic [31:0] exp_mdr   = '0;
    logic        exp_err   = 1'b0;

    int   req_pulses   = 0;
    logic mem_req_prev = 1'b0;

    mem_port_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .i_or_d   (i_or_d),
        .ir_write (ir_write),
        .pc       (pc),
        .alu_out  (alu_out),
        .wdata    (wdata),
        .cpu_stall(cpu_stall),
        .instr    (instr),
        .mdr      (mdr),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    always #5 clk = ~clk;

    // Count rising edges of mem_req, sampled away from the active edge.
    always @(negedge clk) begin
        if (mem_req && !mem_req_prev) req_pulses++;
        mem_req_prev = mem_req;
    end

    task automatic apply_reset();
        reset = 1'b1; cpu_req = 0; cpu_we = 0; i_or_d = 0; ir_write = 0;
        pc = '0; alu_out = '0; wdata = '0; mem_rdata = '0; mem_ack = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_instr = '0; exp_mdr = '0; exp_err = 1'b0;
    endtask

    // One complete access. wait_n = unacknowledged BUSY cycles before the ack;
    // wait_n >= TO means memory never answers. hold keeps cpu_req high through DONE.
    task automatic access(input string name, input bit fetch, input bit we, input bit iord,
                          input logic [31:0] a_pc, input logic [31:0] a_alu,
                          input logic [31:0] a_wdata, input logic [31:0] a_rdata,
                          input int wait_n, input bit hold);
        logic [31:0] addr;
        int          busy_n;
        bit          acked;
        addr = iord ? a_alu : a_pc;
        @(negedge clk);
        cpu_req = 1; cpu_we = we; i_or_d = iord; ir_write = fetch;
        pc = a_pc; alu_out = a_alu; wdata = a_wdata; mem_ack = 0;
        #1;
        checks++;
        if (cpu_stall !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s req_cycle: cpu_stall=%b mem_req=%b, required cpu_stall=1 mem_req=0",
                     name, cpu_stall, mem_req);
        end
        if (addr[1:0] != 2'b00) begin
            exp_err = 1'b1;
        end else begin
            acked  = (wait_n < TO);
            busy_n = acked ? wait_n + 1 : TO;
            for (int k = 0; k < busy_n; k++) begin
                @(negedge clk);
                if (acked && k == wait_n) begin
                    mem_ack = 1; mem_rdata = a_rdata;
                end else begin
                    mem_ack = 0; mem_rdata = $urandom;
                end
                #1;
                checks++;
                if (mem_req !== 1'b1 || cpu_stall !== 1'b1 || mem_we !== we ||
                    mem_addr !== {addr[31:2], 2'b00} || (we && mem_wdata !== a_wdata)) begin
                    errors++;
                    $display("FAIL %s busy_cycle%0d: req=%b stall=%b we=%b addr=%h wdata=%h, required req=1 stall=1 we=%b addr=%h wdata=%h",
                             name, k, mem_req, cpu_stall, mem_we, mem_addr, mem_wdata,
                             we, {addr[31:2], 2'b00}, a_wdata);
                end
            end
            if (acked) begin
                if (!we) begin
                    if (fetch) exp_instr = a_rdata;
                    else       exp_mdr   = a_rdata;
                end
            end else begin
                exp_err = 1'b1;
            end
        end
        @(negedge clk);
        mem_ack = 0;
        if (!hold) cpu_req = 0;
        #1;
        checks++;
        if (cpu_stall !== 1'b0 || mem_req !== 1'b0 || instr !== exp_instr ||
            mdr !== exp_mdr || err !== exp_err) begin
            errors++;
            $display("FAIL %s done_cycle: stall=%b req=%b instr=%h mdr=%h err=%b, required stall=0 req=0 instr=%h mdr=%h err=%b",
                     name, cpu_stall, mem_req, instr, mdr, err, exp_instr, exp_mdr, exp_err);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (cpu_stall !== 0 || mem_req !== 0 || mem_we !== 0 || err !== 0 ||
            instr !== 32'h0 || mdr !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL %s: stall=%b req=%b we=%b err=%b instr=%h mdr=%h addr=%h wdata=%h, required all zero",
                     name, cpu_stall, mem_req, mem_we, err, instr, mdr, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_req = 0; cpu_we = 0; i_or_d = 0; ir_write = 0;
        pc = '0; alu_out = '0; wdata = '0; mem_rdata = '0; mem_ack = 0;
        @(negedge clk); #1;
        check_reset_outputs("reset_asserted");
        apply_reset();
        #1;
        check_reset_outputs("reset_released");
    endtask

    task automatic test_fetch();
        access("fetch", 1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h8C220004, 0, 0);
    endtask

    task automatic test_load();
        access("load_wait", 0, 0, 1, 32'h44, 32'h104, 32'h0, 32'hDEADBEEF, 4, 0);
    endtask

    task automatic test_store();
        access("store", 0, 1, 1, 32'h48, 32'h200, 32'h12345678, 32'hFFFFFFFF, 3, 0);
    endtask

    task automatic test_misaligned();
        access("misaligned", 0, 0, 1, 32'h4C, 32'h102, 32'h0, 32'hAAAA5555, 0, 0);
    endtask

    task automatic test_timeout();
        access("timeout", 0, 0, 1, 32'h50, 32'h300, 32'h0, 32'h11111111, TO, 0);
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; i_or_d = 0; ir_write = 1; pc = 32'h80;
        @(negedge clk); #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy_entry: mem_req=%b, required 1", mem_req);
        end
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("reset_mid_busy");
        @(negedge clk);
        cpu_req = 0; reset = 1'b0;
        exp_instr = '0; exp_mdr = '0; exp_err = 1'b0;
        access("fetch_after_reset", 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h2008000A, 1, 0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk); #1;
        req_pulses = 0;
        access("b2b_fetch", 1, 0, 0, 32'h100, 32'h0, 32'h0, 32'h8FA80010, 0, 1);
        access("b2b_load", 0, 0, 1, 32'h104, 32'h3F0, 32'h0, 32'hCAFEF00D, 2, 0);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (req_pulses !== 2 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_pulses: pulses=%0d mem_req=%b, required pulses=2 mem_req=0",
                     req_pulses, mem_req);
        end
    endtask

    task automatic test_spurious_ack();
        @(negedge clk); #1;
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL spurious_ack_before: err=%b, required %b", err, exp_err);
        end
        @(negedge clk);
        mem_ack = 1; mem_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        mem_ack = 0;
        exp_err = 1'b1;
        #1;
        checks++;
        if (err !== exp_err || instr !== exp_instr || mdr !== exp_mdr || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL spurious_ack_after: err=%b instr=%h mdr=%h req=%b, required err=1 instr=%h mdr=%h req=0",
                     err, instr, mdr, mem_req, exp_instr, exp_mdr);
        end
    endtask

    task automatic test_random();
        int          kind;
        logic [31:0] addr, data, wd;
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 2);
            addr = {20'h0, 10'($urandom), 2'b00};
            if ($urandom_range(0, 5) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            data = $urandom;
            wd   = $urandom;
            case (kind)
                0:       access("rnd_fetch", 1, 0, 0, addr, $urandom, wd, data,
                                $urandom_range(0, 6), 1'($urandom_range(0, 1)));
                1:       access("rnd_load", 0, 0, 1, $urandom, addr, wd, data,
                                $urandom_range(0, 6), 1'($urandom_range(0, 1)));
                default: access("rnd_store", 0, 1, 1, $urandom, addr, wd, data,
                                $urandom_range(0, 6), 1'($urandom_range(0, 1)));
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        test_spurious_ack();
        apply_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
